// File: rtl/delay_sum_beamformer.sv
// delay_sum_beamformer: per-channel delay lines, serial channel sum, scaled result per frame.
// Optional feature macro: BF_SATURATE_EN (clamp the scaled sum instead of wrapping).
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_in_valid, i_in_data frame strobe and N_CH packed signed samples (channel c at [c*W +: W])
//   i_cfg_we/ch/delay     shadow delay write for one channel
//   o_out_valid/o_out_data one-cycle result strobe and held scaled sum
//   o_busy, o_overrun     summing in progress, sticky dropped-frame flag
module delay_sum_beamformer #(
    parameter int N_CH  = 4,
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int SHIFT = $clog2(N_CH)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    input  logic [N_CH*W-1:0]          i_in_data,
    input  logic                       i_cfg_we,
    input  logic [$clog2(N_CH)-1:0]    i_cfg_ch,
    input  logic [$clog2(DEPTH)-1:0]   i_cfg_delay,
    output logic                       o_out_valid,
    output logic [W-1:0]               o_out_data,
    output logic                       o_busy,
    output logic                       o_overrun
);
    localparam int CW = $clog2(N_CH);
    localparam int DW = $clog2(DEPTH);
    localparam int AW = W + CW;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                r_state, w_next;
    logic [W-1:0]          r_buf [N_CH][DEPTH];
    logic [DW-1:0]         r_shadow [N_CH];
    logic [DW-1:0]         r_active [N_CH];
    logic [DW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_ch;
    logic signed [AW-1:0]  r_acc;
    logic [DW-1:0]         w_rd;
    logic [W-1:0]          w_samp;
    logic [W-1:0]          w_scaled;
    logic                  w_accept;

    assign w_accept = i_in_valid && (r_state == IDLE);
    assign o_busy   = (r_state != IDLE);
    // The current frame sits one slot behind the already-advanced write pointer.
    assign w_rd     = r_wr_ptr - DW'(1) - r_active[r_ch];
    assign w_samp   = r_buf[r_ch][w_rd];

`ifdef BF_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (W - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [AW-1:0] w_sh;
    assign w_sh     = r_acc >>> SHIFT;
    assign w_scaled = (w_sh > SAT_MAX) ? SAT_MAX[W-1:0] :
                      (w_sh < SAT_MIN) ? SAT_MIN[W-1:0] : w_sh[W-1:0];
`else
    assign w_scaled = W'(r_acc >>> SHIFT);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_in_valid ? ACC : IDLE;
            ACC:     w_next = (r_ch == CW'(N_CH - 1)) ? OUT : ACC;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_ch        <= '0;
            r_acc       <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_overrun   <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_shadow[c] <= '0;
                r_active[c] <= '0;
                for (int d = 0; d < DEPTH; d++) r_buf[c][d] <= '0;
            end
        end else begin
            r_state     <= w_next;
            o_out_valid <= (r_state == OUT);
            if (w_accept) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_buf[c][r_wr_ptr] <= i_in_data[c*W +: W];
                    r_active[c]        <= r_shadow[c];
                end
                r_wr_ptr <= r_wr_ptr + DW'(1);
                r_acc    <= '0;
                r_ch     <= '0;
            end
            if (i_in_valid && r_state != IDLE) o_overrun <= 1'b1;
            if (r_state == ACC) begin
                r_acc <= r_acc + {{CW{w_samp[W-1]}}, w_samp};
                r_ch  <= r_ch + CW'(1);
            end
            if (r_state == OUT) o_out_data <= w_scaled;
            if (i_cfg_we && int'(i_cfg_ch) < N_CH) r_shadow[i_cfg_ch] <= i_cfg_delay;
        end
    end
endmodule
